reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state updates on posedge clk); reset input 1 (synchronous, active-high).
REQ-002 The block SHALL provide these ports:
- issue_valid  in  1  ID-stage instruction requests issue.
- rs1, rs2  in  5  source register addresses.
- rs1_used, rs2_used  in  1  source actually read by instruction.
- rd  in  5  destination address.
- rd_we  in  1  instruction will write rd.
- issue_ready  out  1  no hazard; issue accepted when issue_valid & issue_ready.
- ret_valid  in  1  WB-stage write (same qualifier as register-file write enable).
- ret_rd  in  5  WB destination address.
- kill_valid  in  1  squashed in-flight instruction releases its reservation.
- kill_rd  in  5  squashed instruction's destination.
- busy  out  1  any register has a pending write.
- err  out  1  sticky underflow/overflow flag.

Function
REQ-003 The block SHALL hold a 2-bit pending counter pend[r] for r = 1..31; x0 has no counter and is never pending.
REQ-004 An accepted issue with rd_we=1 and rd!=0 SHALL add 1 to pend[rd] at the next posedge.
REQ-005 ret_valid with ret_rd!=0 SHALL subtract 1 from pend[ret_rd]; kill_valid with kill_rd!=0 SHALL subtract 1 from pend[kill_rd].
REQ-006 Simultaneous events on one register SHALL sum: issue + retire nets 0; retire + kill on the same register nets -2; issue + retire + kill nets -1.
REQ-007 A decrement that would take pend below 0 SHALL clamp at 0 and set err.
REQ-008 An issue that would take pend above 3 SHALL be prevented by stalling (REQ-010), so no wrap occurs; an overflow reaching the counter anyway SHALL clamp at 3 and set err.
REQ-009 The source hazard is haz_s = rsX_used & rsX!=0 & pend[rsX]!=0, with bypass per REQ-016.
REQ-010 issue_ready SHALL be combinational and SHALL equal NOT(haz_1 OR haz_2 OR (rd_we & rd!=0 & pend[rd]==3)).
REQ-011 issue_ready SHALL NOT depend on issue_valid; when issue_valid=0 no counter changes from the issue path.
REQ-012 busy SHALL be registered and equal OR of (pend[r]!=0), reflecting state after the last posedge.
REQ-013 err, once set, SHALL remain 1 until reset.
REQ-014 Issue latency SHALL be: a reservation made at edge N stalls a dependent reader from cycle N+1 onward.

Reset
REQ-015 With reset=1 at a posedge, all pend[r] SHALL become 0 and busy and err SHALL become 0, overriding any simultaneous issue, retire or kill. issue_ready SHALL be 1 in the cycle after reset whenever the counters are 0.

Configuration
REQ-016 Macro SCOREBOARD_BYPASS_EN SHALL control same-cycle retire bypass.
- Defined: a source is not hazardous when ret_valid & ret_rd==rsX & pend[rsX]==1. The register file writes on negedge, so the value is readable that cycle.
- Undefined: no bypass; the reader stalls until the cycle after the retire edge.

Verification
REQ-017 Reset, then issue rd=5; next cycle issue rs1=5, rs1_used=1 -> issue_ready=0, busy=1.
REQ-018 With pend[5]=1, assert ret_valid, ret_rd=5 while rs1=5 waits:
- macro defined -> issue_ready=1 that cycle.
- macro undefined -> issue_ready=0 that cycle, 1 the next cycle.
REQ-019 Three issues to rd=7 with no retires -> pend[7]=3; a fourth issue to rd=7 -> issue_ready=0, err stays 0.
REQ-020 With pend[9]=2, apply ret_rd=9 and kill_rd=9 in the same cycle -> pend[9]=0 and busy=0 next cycle. Then retire rd=9 again -> err=1 and remains 1.
REQ-021 Issue rd=0 and rs1=0 repeatedly -> issue_ready=1 always and busy=0. Then ret_rd=0 -> err stays 0.
REQ-022 With pend[3]=2, assert reset together with an issue to rd=3 -> all counters 0 and busy=0 and err=0 after the edge.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Issue/retire/kill bus of the register scoreboard, with master (pipeline) and
// slave (scoreboard) views.
interface reg_scoreboard_if;
  logic       issue_valid;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic [4:0] rd;
  logic       rd_we;
  logic       issue_ready;
  logic       ret_valid;
  logic [4:0] ret_rd;
  logic       kill_valid;
  logic [4:0] kill_rd;
  logic       busy;
  logic       err;

  modport master (
    output issue_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_we,
    output ret_valid, ret_rd, kill_valid, kill_rd,
    input  issue_ready, busy, err
  );

  modport slave (
    input  issue_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_we,
    input  ret_valid, ret_rd, kill_valid, kill_rd,
    output issue_ready, busy, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: 2-bit pending counters for x1..x31, issue stall,
// busy summary and sticky error. Macro SCOREBOARD_BYPASS_EN enables same-cycle
// retire bypass for sources.
module reg_scoreboard (
  input  logic            clk,
  input  logic            reset,
  reg_scoreboard_if.slave sb
);

  // Entry 0 exists only so x0 can be indexed; it is held at zero.
  logic [1:0] pend     [32];
  logic [1:0] pend_nxt [32];

  logic busy_q;
  logic err_q;
  logic busy_nxt;
  logic err_hit;

  logic haz1;
  logic haz2;
  logic rd_full;
  logic ready;
  logic issue_fire;

  always_comb begin
    haz1 = sb.rs1_used && (sb.rs1 != '0) && (pend[sb.rs1] != '0);
    haz2 = sb.rs2_used && (sb.rs2 != '0) && (pend[sb.rs2] != '0);
`ifdef SCOREBOARD_BYPASS_EN
    // Register file writes on negedge, so the last pending write is readable now.
    if (sb.ret_valid && (sb.ret_rd == sb.rs1) && (pend[sb.rs1] == 2'd1)) haz1 = 1'b0;
    if (sb.ret_valid && (sb.ret_rd == sb.rs2) && (pend[sb.rs2] == 2'd1)) haz2 = 1'b0;
`endif
    rd_full    = sb.rd_we && (sb.rd != '0) && (pend[sb.rd] == 2'd3);
    ready      = !(haz1 || haz2 || rd_full);
    issue_fire = sb.issue_valid && ready && sb.rd_we && (sb.rd != '0);
  end

  // Simultaneous issue/retire/kill on one register are summed, then clamped.
  always_comb begin
    pend_nxt[0] = '0;
    busy_nxt    = 1'b0;
    err_hit     = 1'b0;
    for (int unsigned r = 1; r < 32; r++) begin
      logic signed [3:0] sum;
      sum = {2'b00, pend[r]};
      if (issue_fire && (sb.rd == r[4:0]))          sum = sum + 4'sd1;
      if (sb.ret_valid && (sb.ret_rd == r[4:0]))    sum = sum - 4'sd1;
      if (sb.kill_valid && (sb.kill_rd == r[4:0]))  sum = sum - 4'sd1;
      if (sum[3]) begin
        pend_nxt[r] = 2'd0;
        err_hit     = 1'b1;
      end else if (sum[2]) begin
        pend_nxt[r] = 2'd3;
        err_hit     = 1'b1;
      end else begin
        pend_nxt[r] = sum[1:0];
      end
      if (pend_nxt[r] != '0) busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < 32; r++) pend[r] <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < 32; r++) pend[r] <= pend_nxt[r];
      busy_q <= busy_nxt;
      err_q  <= err_q || err_hit;
    end
  end

  assign sb.issue_ready = ready;
  assign sb.busy        = busy_q;
  assign sb.err         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: integer pending-count model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_scoreboard_if sb_if ();

  reg_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  int passed = 0;
  int total  = 0;
  bit started = 1'b0;

  // Model: plain integer pending counts per architectural register.
  int m_pend [32];
  bit m_err = 1'b0;

  task automatic check(input string name, input logic actual, input logic exp);
    total++;
    if (actual !== exp)
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, actual, exp, $time);
    else
      passed++;
  endtask

  function automatic bit m_src_haz(input bit used, input int rs);
    bit h;
    h = used && (rs != 0) && (m_pend[rs] > 0);
    if (BYP && sb_if.ret_valid && (int'(sb_if.ret_rd) == rs) && (m_pend[rs] == 1)) h = 1'b0;
    return h;
  endfunction

  function automatic bit m_ready();
    bit full;
    full = sb_if.rd_we && (sb_if.rd != 0) && (m_pend[sb_if.rd] == 3);
    return !(m_src_haz(sb_if.rs1_used, int'(sb_if.rs1)) ||
             m_src_haz(sb_if.rs2_used, int'(sb_if.rs2)) || full);
  endfunction

  function automatic bit m_busy();
    for (int r = 1; r < 32; r++) if (m_pend[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  initial for (int r = 0; r < 32; r++) m_pend[r] = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
      m_err = 1'b0;
    end else begin
      int delta [32];
      bit rdy;
      rdy = m_ready();
      for (int r = 0; r < 32; r++) delta[r] = 0;
      if (sb_if.issue_valid && rdy && sb_if.rd_we) delta[sb_if.rd] += 1;
      if (sb_if.ret_valid)  delta[sb_if.ret_rd]  -= 1;
      if (sb_if.kill_valid) delta[sb_if.kill_rd] -= 1;
      for (int r = 1; r < 32; r++) begin
        int n;
        n = m_pend[r] + delta[r];
        if (n < 0) begin n = 0; m_err = 1'b1; end
        if (n > 3) begin n = 3; m_err = 1'b1; end
        m_pend[r] = n;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_issue_ready", sb_if.issue_ready, m_ready());
      check("model_busy", sb_if.busy, m_busy());
      check("model_err", sb_if.err, m_err);
    end
  end

  task automatic idle();
    sb_if.issue_valid = 1'b0;
    sb_if.rs1 = '0; sb_if.rs2 = '0;
    sb_if.rs1_used = 1'b0; sb_if.rs2_used = 1'b0;
    sb_if.rd = '0; sb_if.rd_we = 1'b0;
    sb_if.ret_valid = 1'b0; sb_if.ret_rd = '0;
    sb_if.kill_valid = 1'b0; sb_if.kill_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] d);
    sb_if.issue_valid = 1'b1; sb_if.rd_we = 1'b1; sb_if.rd = d;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check("reset_ready", sb_if.issue_ready, 1'b1);
    check("reset_busy", sb_if.busy, 1'b0);
    check("reset_err", sb_if.err, 1'b0);

    // RAW stall on x5
    step(); issue_wr(5'd5); step();
    idle(); sb_if.issue_valid = 1'b1; sb_if.rs1 = 5'd5; sb_if.rs1_used = 1'b1;
    @(negedge clk);
    check("raw_stall_ready", sb_if.issue_ready, 1'b0);
    check("raw_stall_busy", sb_if.busy, 1'b1);
    step();
    // retire x5 while the reader waits
    sb_if.ret_valid = 1'b1; sb_if.ret_rd = 5'd5;
    @(negedge clk);
    check("retire_bypass_ready", sb_if.issue_ready, BYP);
    step();
    sb_if.ret_valid = 1'b0;
    @(negedge clk);
    check("after_retire_ready", sb_if.issue_ready, 1'b1);
    check("after_retire_busy", sb_if.busy, 1'b0);
    step();

    // saturate x7
    idle();
    repeat (3) begin issue_wr(5'd7); step(); end
    @(negedge clk);
    check("x7_full_ready", sb_if.issue_ready, 1'b0);
    check("x7_full_err", sb_if.err, 1'b0);
    step(); step();
    @(negedge clk);
    check("x7_stalled_err", sb_if.err, 1'b0);
    idle();
    sb_if.rs2 = 5'd7; sb_if.rs2_used = 1'b1;
    @(negedge clk);
    check("x7_rs2_hazard", sb_if.issue_ready, 1'b0);
    idle();
    repeat (3) begin sb_if.ret_valid = 1'b1; sb_if.ret_rd = 5'd7; step(); end
    idle();

    // retire + kill on x9 nets -2, then underflow
    repeat (2) begin issue_wr(5'd9); step(); end
    idle();
    sb_if.ret_valid = 1'b1; sb_if.ret_rd = 5'd9;
    sb_if.kill_valid = 1'b1; sb_if.kill_rd = 5'd9;
    step();
    idle();
    @(negedge clk);
    check("x9_cleared_busy", sb_if.busy, 1'b0);
    check("x9_cleared_err", sb_if.err, 1'b0);
    sb_if.ret_valid = 1'b1; sb_if.ret_rd = 5'd9;
    step();
    idle();
    @(negedge clk);
    check("x9_underflow_err", sb_if.err, 1'b1);
    step(); step();
    @(negedge clk);
    check("err_sticky", sb_if.err, 1'b1);

    // x0 is never pending
    do_reset();
    repeat (4) begin
      issue_wr(5'd0); sb_if.rs1 = 5'd0; sb_if.rs1_used = 1'b1;
      @(negedge clk);
      check("x0_ready", sb_if.issue_ready, 1'b1);
      check("x0_busy", sb_if.busy, 1'b0);
      step();
    end
    idle();
    sb_if.ret_valid = 1'b1; sb_if.ret_rd = 5'd0;
    sb_if.kill_valid = 1'b1; sb_if.kill_rd = 5'd0;
    step();
    idle();
    @(negedge clk);
    check("x0_retire_err", sb_if.err, 1'b0);

    // issue + retire nets 0; issue + retire + kill nets -1 on x4
    issue_wr(5'd4); step();
    issue_wr(5'd4); sb_if.ret_valid = 1'b1; sb_if.ret_rd = 5'd4; step();
    idle();
    sb_if.rs2 = 5'd4; sb_if.rs2_used = 1'b1;
    @(negedge clk);
    check("x4_net0_hazard", sb_if.issue_ready, 1'b0);
    idle();
    issue_wr(5'd4); sb_if.ret_valid = 1'b1; sb_if.ret_rd = 5'd4;
    sb_if.kill_valid = 1'b1; sb_if.kill_rd = 5'd4;
    step();
    idle();
    @(negedge clk);
    check("x4_netm1_busy", sb_if.busy, 1'b0);
    check("x4_netm1_err", sb_if.err, 1'b0);

    // reset overrides a concurrent issue; err cleared too
    sb_if.ret_valid = 1'b1; sb_if.ret_rd = 5'd12; step();
    idle();
    repeat (2) begin issue_wr(5'd3); step(); end
    @(negedge clk);
    check("pre_reset_busy", sb_if.busy, 1'b1);
    check("pre_reset_err", sb_if.err, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    sb_if.issue_valid = 1'b1; sb_if.rs1 = 5'd3; sb_if.rs1_used = 1'b1;
    @(negedge clk);
    check("post_reset_busy", sb_if.busy, 1'b0);
    check("post_reset_err", sb_if.err, 1'b0);
    check("post_reset_ready", sb_if.issue_ready, 1'b1);
    step();
    idle();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
